// File: rtl/jtframe_ram_rqx.sv
// jtframe_ram_rqx
//   Read/write SDRAM requester bridging one game-side RAM port to one slot
//   of the jtframe SDRAM controller. Game data width DW is 8, 16 or 32 bits
//   (DW=32 is read-only). The game address is latched on a request rising
//   edge, or on an address change while data_ok is held.
//
//   Optional feature macro: JTFRAME_RAM_RQ_CACHE_EN
//     Adds a one-entry read cache (last completed read's SDRAM address and
//     32-bit word). A read that hits the entry completes without a
//     controller request. Writes and offset changes invalidate it.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   cen           qualifies sampling of addr_ok/addr
//   addr, offset  game address (DW units), region base (16-bit words)
//   addr_ok       request level, wrin (1=write), wrdata
//   din, din_ok   SDRAM read data / completion strobe
//   we            controller is serving this slot
//   req, req_rnw  request and direction (1=read) to the controller
//   sdram_addr    16-bit word address (laddr mapped + offset)
//   sdram_wrdata  write data, sdram_ben byte enables (bit 1 = upper byte)
//   data_ok, dout completion level and read data
module jtframe_ram_rqx #(
  parameter int AW = 18,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [AW-1:0] addr,
  input  logic [21:0]   offset,
  input  logic          addr_ok,
  input  logic          wrin,
  input  logic [DW-1:0] wrdata,
  input  logic [31:0]   din,
  input  logic          din_ok,
  input  logic          we,
  output logic          req,
  output logic          req_rnw,
  output logic [21:0]   sdram_addr,
  output logic [15:0]   sdram_wrdata,
  output logic [1:0]    sdram_ben,
  output logic          data_ok,
  output logic [DW-1:0] dout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Game address (DW units) to 16-bit SDRAM word address, modulo 2^22
  function automatic logic [21:0] map_addr(input logic [AW-1:0] a,
                                           input logic [21:0] off);
    if (DW == 8)       return 22'(a >> 1) + off;
    else if (DW == 16) return 22'(a) + off;
    else               return 22'({a, 1'b0}) + off;
  endfunction

  // Pick the game-visible lane out of a 32-bit SDRAM word
  function automatic logic [DW-1:0] lane(input logic [31:0] d, input logic a0);
    if (DW == 8) return DW'(a0 ? d[15:8] : d[7:0]);
    else         return d[DW-1:0];
  endfunction

  function automatic logic [15:0] wr_lanes(input logic [DW-1:0] w);
    if (DW == 8)       return 16'({w, w});
    else if (DW == 16) return 16'(w);
    else               return 16'h0;
  endfunction

  function automatic logic [1:0] ben_of(input logic a0);
    if (DW == 8) return a0 ? 2'b10 : 2'b01;
    else         return 2'b11;
  endfunction

  state_t        st;
  logic [AW-1:0] laddr;
  logic          last_cs;
  logic          rise, restart, start, nwr, hit;
  logic [31:0]   cache_word;

  assign sdram_addr = map_addr(laddr, offset);

  always_comb begin
    rise    = addr_ok & cen & ~last_cs;
    restart = (st == DONE) & cen & addr_ok & (addr != laddr);
    start   = ((st == IDLE) & rise) | restart;
    nwr     = (DW != 32) & wrin;
  end

`ifdef JTFRAME_RAM_RQ_CACHE_EN
  logic [21:0] cache_addr, last_off;
  logic        cache_vld, fill;

  // Completed reads fill the entry; the hit compare also needs an unchanged
  // offset because the stored address was mapped with the old base.
  assign fill       = ((st == REQ) | (st == WAIT)) & we & din_ok & req_rnw;
  assign hit        = cache_vld & ~nwr & (offset == last_off) &
                      (cache_addr == map_addr(addr, offset));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_addr <= '0;
      cache_word <= '0;
      cache_vld  <= 1'b0;
      last_off   <= '0;
    end else begin
      last_off <= offset;
      if (fill) begin
        cache_addr <= sdram_addr;
        cache_word <= din;
        cache_vld  <= 1'b1;
      end
      if ((start & nwr) || (offset != last_off)) cache_vld <= 1'b0;
    end
  end
`else
  assign hit        = 1'b0;
  assign cache_word = 32'h0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      req          <= 1'b0;
      req_rnw      <= 1'b1;
      data_ok      <= 1'b0;
      dout         <= '0;
      sdram_wrdata <= '0;
      sdram_ben    <= 2'b11;
      laddr        <= '0;
      last_cs      <= 1'b0;
    end else begin
      if (cen) last_cs <= addr_ok;
      if (start) begin
        // New access from IDLE or a DONE restart
        laddr        <= addr;
        req_rnw      <= ~nwr;
        sdram_wrdata <= wr_lanes(wrdata);
        sdram_ben    <= ben_of(addr[0]);
        if (hit) begin
          data_ok <= 1'b1;
          dout    <= lane(cache_word, addr[0]);
          st      <= DONE;
        end else begin
          data_ok <= 1'b0;
          req     <= 1'b1;
          st      <= REQ;
        end
      end else begin
        case (st)
          REQ: if (we) begin
            req <= 1'b0;
            if (din_ok) begin
              data_ok <= 1'b1;
              if (req_rnw) dout <= lane(din, laddr[0]);
              st <= DONE;
            end else begin
              st <= WAIT;
            end
          end
          WAIT: if (we && din_ok) begin
            data_ok <= 1'b1;
            if (req_rnw) dout <= lane(din, laddr[0]);
            st <= DONE;
          end
          DONE: if (cen && !addr_ok) begin
            data_ok <= 1'b0;
            st      <= IDLE;
          end
          default: data_ok <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_ram_rqx.sv
module tb_jtframe_ram_rqx;

`ifdef JTFRAME_RAM_RQ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cen, addr_ok, wrin, din_ok, we;
  logic [17:0] addr;
  logic [21:0] offset;
  logic [31:0] wrdata, din;

  logic [2:0]        o_req, o_rnw, o_dok;
  logic [2:0][21:0]  o_sa;
  logic [2:0][15:0]  o_swd;
  logic [2:0][1:0]   o_ben;
  logic [7:0]        dout8;
  logic [15:0]       dout16;
  logic [31:0]       dout32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_ram_rqx #(.AW(18), .DW(8)) u8 (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .offset(offset),
    .addr_ok(addr_ok), .wrin(wrin), .wrdata(wrdata[7:0]), .din(din),
    .din_ok(din_ok), .we(we), .req(o_req[0]), .req_rnw(o_rnw[0]),
    .sdram_addr(o_sa[0]), .sdram_wrdata(o_swd[0]), .sdram_ben(o_ben[0]),
    .data_ok(o_dok[0]), .dout(dout8));

  jtframe_ram_rqx #(.AW(18), .DW(16)) u16 (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .offset(offset),
    .addr_ok(addr_ok), .wrin(wrin), .wrdata(wrdata[15:0]), .din(din),
    .din_ok(din_ok), .we(we), .req(o_req[1]), .req_rnw(o_rnw[1]),
    .sdram_addr(o_sa[1]), .sdram_wrdata(o_swd[1]), .sdram_ben(o_ben[1]),
    .data_ok(o_dok[1]), .dout(dout16));

  jtframe_ram_rqx #(.AW(18), .DW(32)) u32 (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .offset(offset),
    .addr_ok(addr_ok), .wrin(wrin), .wrdata(wrdata), .din(din),
    .din_ok(din_ok), .we(we), .req(o_req[2]), .req_rnw(o_rnw[2]),
    .sdram_addr(o_sa[2]), .sdram_wrdata(o_swd[2]), .sdram_ben(o_ben[2]),
    .data_ok(o_dok[2]), .dout(dout32));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int DWS[3] = '{8, 16, 32};

  function automatic logic [21:0] m_map(int dw, logic [17:0] a, logic [21:0] off);
    longint t;
    t = (dw == 8) ? a / 2 : (dw == 16) ? a : a * 2;
    return 22'((t + off) % (1 << 22));
  endfunction

  function automatic logic [31:0] m_lane(int dw, logic [31:0] d, logic [17:0] a);
    if (dw == 8)  return (d >> (a % 2 * 8)) & 32'hFF;
    if (dw == 16) return d & 32'hFFFF;
    return d;
  endfunction

  // Per-instance transaction view: awaiting grant, granted awaiting data,
  // or holding a completed result.
  logic [17:0] m_la[3];
  bit          m_lw[3], m_req[3], m_grant[3], m_dok[3], m_cv[3];
  logic [31:0] m_dout[3], m_cd[3];
  logic [15:0] m_swd[3];
  logic [1:0]  m_ben[3];
  logic [21:0] m_ca[3];
  logic [21:0] m_poff;
  bit          m_lcs;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_la[i] = '0; m_lw[i] = 0; m_req[i] = 0; m_grant[i] = 0; m_dok[i] = 0;
        m_cv[i] = 0; m_dout[i] = '0; m_swd[i] = '0; m_ben[i] = 2'b11;
      end
      m_poff = '0; m_lcs = 0;
    end else begin
      bit rise_m, offchg, hit;
      rise_m = addr_ok && cen && !m_lcs;
      offchg = offset != m_poff;
      for (int i = 0; i < 3; i++) begin
        int  dw;
        bit  do_start, do_done;
        dw = DWS[i]; do_start = 0; do_done = 0;
        if (m_dok[i]) begin
          if (cen && !addr_ok) m_dok[i] = 0;
          else if (cen && addr != m_la[i]) do_start = 1;
        end else if (m_req[i]) begin
          if (we) begin
            m_req[i] = 0;
            if (din_ok) do_done = 1; else m_grant[i] = 1;
          end
        end else if (m_grant[i]) begin
          if (we && din_ok) begin m_grant[i] = 0; do_done = 1; end
        end else if (rise_m) do_start = 1;

        if (do_done) begin
          m_dok[i] = 1;
          if (!m_lw[i]) begin
            m_dout[i] = m_lane(dw, din, m_la[i]);
            if (CACHE) begin m_cv[i] = 1; m_ca[i] = m_map(dw, m_la[i], offset); m_cd[i] = din; end
          end
        end
        if (do_start) begin
          m_la[i]  = addr;
          m_lw[i]  = (dw != 32) && wrin;
          m_swd[i] = (dw == 8) ? wrdata[7:0] * 16'h0101 : (dw == 16) ? wrdata[15:0] : 16'h0;
          m_ben[i] = (dw == 8) ? 2'(1 << (addr % 2)) : 2'b11;
          hit = CACHE && !m_lw[i] && m_cv[i] && !offchg && m_ca[i] == m_map(dw, addr, offset);
          if (m_lw[i]) m_cv[i] = 0;
          m_grant[i] = 0;
          if (hit) begin m_dok[i] = 1; m_dout[i] = m_lane(dw, m_cd[i], addr); end
          else begin m_dok[i] = 0; m_req[i] = 1; end
        end
      end
      if (offchg) for (int i = 0; i < 3; i++) m_cv[i] = 0;
      if (cen) m_lcs = addr_ok;
      m_poff = offset;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] dv;
      dv = (i == 0) ? {24'h0, dout8} : (i == 1) ? {16'h0, dout16} : dout32;
      check($sformatf("req[%0d]", i),     {31'h0, o_req[i]}, {31'h0, m_req[i]});
      check($sformatf("req_rnw[%0d]", i), {31'h0, o_rnw[i]}, {31'h0, !m_lw[i]});
      check($sformatf("data_ok[%0d]", i), {31'h0, o_dok[i]}, {31'h0, m_dok[i]});
      check($sformatf("saddr[%0d]", i),   {10'h0, o_sa[i]},  {10'h0, m_map(DWS[i], m_la[i], offset)});
      check($sformatf("swd[%0d]", i),     {16'h0, o_swd[i]}, {16'h0, m_swd[i]});
      check($sformatf("ben[%0d]", i),     {30'h0, o_ben[i]}, {30'h0, m_ben[i]});
      check($sformatf("dout[%0d]", i),    dv, m_dout[i]);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; cen = 1; addr_ok = 0; wrin = 0; din_ok = 0; we = 0;
    addr = '0; offset = 22'h100; wrdata = '0; din = '0;
    step(); step();
    check("rst_req", {31'h0, o_req[0]}, 0);
    check("rst_rnw", {31'h0, o_rnw[0]}, 1);
    check("rst_ben", {30'h0, o_ben[0]}, 32'h3);
    check("rst_dout", {24'h0, dout8}, 0);
    rst = 0; step();

    // DW=8 read, odd byte, grant in cycle 3, data in cycle 5
    addr = 18'd5; addr_ok = 1;
    step(); check("t1_req_c1", {31'h0, o_req[0]}, 1);
    step();
    step(); check("t1_req_c3", {31'h0, o_req[0]}, 1); we = 1;
    step(); check("t1_req_c4", {31'h0, o_req[0]}, 0);
    we = 0; din_ok = 1; din = 32'hFFFF_FFFF;   // din_ok without we: ignored
    step(); we = 1; din_ok = 1; din = 32'h0000_ABCD;
    check("t1_dok_c5", {31'h0, o_dok[0]}, 0);
    step(); we = 0; din_ok = 0;
    check("t1_dok_c6", {31'h0, o_dok[0]}, 1);
    check("t1_dout8", {24'h0, dout8}, 32'hAB);
    check("t1_saddr8", {10'h0, o_sa[0]}, 32'h102);
    check("t1_dout16", {16'h0, dout16}, 32'hABCD);
    check("t1_dout32", dout32, 32'h0000_ABCD);
    step(); addr_ok = 0;
    step(); check("t1_idle_dok", {31'h0, o_dok[0]}, 0);
    din_ok = 1; we = 1; step(); din_ok = 0; we = 0;   // din_ok in IDLE: ignored
    step();

    // DW=8 write, even byte
    addr = 18'd4; wrin = 1; wrdata = 32'h1234_565A; addr_ok = 1;
    step();
    check("t2_rnw8", {31'h0, o_rnw[0]}, 0);
    check("t2_swd8", {16'h0, o_swd[0]}, 32'h5A5A);
    check("t2_ben8", {30'h0, o_ben[0]}, 32'h1);
    check("t2_rnw32", {31'h0, o_rnw[2]}, 1);
    we = 1; din_ok = 1; din = 32'h7777_7777;
    step(); check("t2_dok8", {31'h0, o_dok[0]}, 1);
    we = 0; din_ok = 0; addr_ok = 0; wrin = 0;
    step(); step();

    // DW=16 restart on address change while held in DONE
    addr = 18'd10; addr_ok = 1;
    step(); we = 1; din_ok = 1; din = 32'h0000_2222;
    step(); we = 0; din_ok = 0;
    step(); addr = 18'd11;
    step();
    check("t3_dok16", {31'h0, o_dok[1]}, 0);
    check("t3_req16", {31'h0, o_req[1]}, 1);
    check("t3_saddr16", {10'h0, o_sa[1]}, 32'h10B);
    we = 1; din_ok = 1; din = 32'h0000_3333;
    step(); check("t3_dout16", {16'h0, dout16}, 32'h3333);
    we = 0; din_ok = 0; addr_ok = 0;
    step(); step();

    // DW=32 ignores wrin
    offset = 22'h0; addr = 18'd3; wrin = 1; addr_ok = 1;
    step();
    check("t4_rnw32", {31'h0, o_rnw[2]}, 1);
    check("t4_saddr32", {10'h0, o_sa[2]}, 32'h6);
    we = 1; din_ok = 1; din = 32'hDEAD_BEEF;
    step(); check("t4_dout32", dout32, 32'hDEAD_BEEF);
    we = 0; din_ok = 0; addr_ok = 0; wrin = 0;
    step(); step();

    // Reset during WAIT abandons the access
    addr = 18'd7; addr_ok = 1;
    step(); we = 1;
    step(); we = 0;
    step(); rst = 1; #1;
    check("t5_req", {31'h0, o_req[0]}, 0);
    check("t5_dok", {31'h0, o_dok[0]}, 0);
    addr_ok = 0;
    step(); rst = 0;
    step(); we = 1; din_ok = 1;
    step(); we = 0; din_ok = 0;
    check("t5_late_dok", {31'h0, o_dok[0]}, 0);
    step();

    // cen gating, then addr_ok falling mid-access
    cen = 0; addr = 18'd20; addr_ok = 1;
    step(); check("t7_cen_blocks", {31'h0, o_req[0]}, 0);
    cen = 1;
    step(); check("t7_req", {31'h0, o_req[0]}, 1);
    addr_ok = 0; we = 1;
    step(); we = 0;
    step(); din_ok = 1; we = 1;
    step(); din_ok = 0; we = 0;
    check("t7_dok_one", {31'h0, o_dok[0]}, 1);
    step(); check("t7_dok_gone", {31'h0, o_dok[0]}, 0);

    // Adjacent byte reads sharing one SDRAM word
    offset = 22'h100; step(); step();
    addr = 18'd8; addr_ok = 1;
    step(); we = 1; din_ok = 1; din = 32'h0000_1234;
    step(); we = 0; din_ok = 0; addr_ok = 0;
    step(); addr = 18'd9; addr_ok = 1;
    step();
`ifdef JTFRAME_RAM_RQ_CACHE_EN
    check("t6_hit_req", {31'h0, o_req[0]}, 0);
    check("t6_hit_dok", {31'h0, o_dok[0]}, 1);
    check("t6_hit_dout", {24'h0, dout8}, 32'h12);
`else
    check("t6_req", {31'h0, o_req[0]}, 1);
    check("t6_dok", {31'h0, o_dok[0]}, 0);
`endif
    we = 1; din_ok = 1; din = 32'h0000_5678;
    step(); we = 0; din_ok = 0; addr_ok = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
